fpdiv_mant_iter: RTL



---
 rtl/fpdiv_mant_iter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fpdiv_mant_iter.sv
// ---------------------------------------------------------------------------
// fpdiv_mant_iter
//
// Iterative restoring divider for the significands of the fpdiv datapath.
// Produces one quotient bit per clock and answers the fpdiv start/done
// handshake, so the rounding/normalization stage sees the same interface the
// combinational mantissa path used to provide.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   start     in   request; only a rising edge seen in IDLE is accepted
//   a_mant    in   [MW-1:0] dividend significand (hidden bit included)
//   b_mant    in   [MW-1:0] divisor significand (hidden bit included)
//   busy      out  high while iterating
//   done      out  one-cycle completion pulse
//   quotient  out  [QW-1:0] integer bit, MW-1 fraction bits, guard, round
//   sticky    out  set when the final remainder is nonzero
//   dz        out  divide-by-zero flag
//
// Build option:
//   FPDIV_MANT_DZ_EN  when defined, a zero divisor skips the iteration and
//                     completes on the following cycle with quotient all
//                     ones, sticky=1 and dz=1. When undefined, dz is tied
//                     low and a zero divisor simply runs the full iteration.
// ---------------------------------------------------------------------------
module fpdiv_mant_iter #(
  parameter int MW = 53,
  parameter int QW = 55
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic          sticky,
  output logic          dz
);

  // Remainder carries three headroom bits so a < 2 and b >= 1 never overflow.
  localparam int RW = MW + 3;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_start_q;
  logic [RW-1:0] r_rem;
  logic [MW-1:0] r_div;
  // Holds the QW-1 bits already produced; the last bit is appended on the
  // copy into the quotient register.
  logic [QW-2:0] r_qsr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [QW-1:0] r_quot;
  logic          r_sticky;

  state_t        w_state_nxt;
  logic [RW-1:0] w_rem_nxt;
  logic [MW-1:0] w_div_nxt;
  logic [QW-2:0] w_qsr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [QW-1:0] w_quot_nxt;
  logic          w_sticky_nxt;

  logic          w_accept;
  logic [RW-1:0] w_div_ext;
  logic          w_ge;
  logic [RW-1:0] w_sel;
  logic [RW-1:0] w_rem_sh;

`ifdef FPDIV_MANT_DZ_EN
  logic          r_dz;
  logic          w_dz_nxt;
`endif

  // A request is a fresh rising edge of start observed while idle.
  assign w_accept  = start & ~r_start_q & (r_state == S_IDLE);

  // One restoring step: subtract when it fits, then shift the remainder.
  assign w_div_ext = {3'b000, r_div};
  assign w_ge      = (r_rem >= w_div_ext);
  assign w_sel     = w_ge ? (r_rem - w_div_ext) : r_rem;
  assign w_rem_sh  = {w_sel[RW-2:0], 1'b0};

  // Next-state and next-datapath values for the divider FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_div_nxt    = r_div;
    w_qsr_nxt    = r_qsr;
    w_cnt_nxt    = r_cnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_quot_nxt   = r_quot;
    w_sticky_nxt = r_sticky;
`ifdef FPDIV_MANT_DZ_EN
    w_dz_nxt     = r_dz;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_rem_nxt = {3'b000, a_mant};
          w_div_nxt = b_mant;
          w_qsr_nxt = {(QW-1){1'b0}};
          w_cnt_nxt = {CW{1'b0}};
`ifdef FPDIV_MANT_DZ_EN
          w_dz_nxt  = 1'b0;
          if (b_mant == {MW{1'b0}}) begin
            // Zero divisor: report immediately instead of iterating.
            w_state_nxt  = S_DONE;
            w_busy_nxt   = 1'b0;
            w_quot_nxt   = {QW{1'b1}};
            w_sticky_nxt = 1'b1;
            w_dz_nxt     = 1'b1;
          end else begin
            w_state_nxt  = S_RUN;
            w_busy_nxt   = 1'b1;
          end
`else
          w_state_nxt = S_RUN;
          w_busy_nxt  = 1'b1;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_rem_nxt = w_rem_sh;
        w_qsr_nxt = {r_qsr[QW-3:0], w_ge};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) begin
          // Last bit: publish the full quotient and the remainder flag.
          w_state_nxt  = S_DONE;
          w_busy_nxt   = 1'b0;
          w_quot_nxt   = {r_qsr, w_ge};
          w_sticky_nxt = |w_sel;
        end else begin
          w_state_nxt  = S_RUN;
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_rem     <= {RW{1'b0}};
      r_div     <= {MW{1'b0}};
      r_qsr     <= {(QW-1){1'b0}};
      r_cnt     <= {CW{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= {QW{1'b0}};
      r_sticky  <= 1'b0;
`ifdef FPDIV_MANT_DZ_EN
      r_dz      <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_start_q <= start;
      r_rem     <= w_rem_nxt;
      r_div     <= w_div_nxt;
      r_qsr     <= w_qsr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_quot    <= w_quot_nxt;
      r_sticky  <= w_sticky_nxt;
`ifdef FPDIV_MANT_DZ_EN
      r_dz      <= w_dz_nxt;
`endif
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quot;
  assign sticky   = r_sticky;
`ifdef FPDIV_MANT_DZ_EN
  assign dz       = r_dz;
`else
  assign dz       = 1'b0;
`endif

endmodule
